// File: rtl/fetch_redirect_if.sv
// Fetch redirect handshake bundle: decode-stage branch resolution in,
// fetch/IF-ID/predictor control and performance counters out.
interface fetch_redirect_if #(
  parameter int CNT_W = 16
) ();
  logic             id_valid;
  logic             is_branch;
  logic             is_halt;
  logic             actual_taken;
  logic [15:0]      actual_target;
  logic [1:0]       IF_ID_prediction;
  logic [15:0]      IF_ID_predicted_target;
  logic             hazard_stall;
  logic             pc_en;
  logic             IF_ID_en;
  logic             IF_ID_flush;
  logic             update_PC;
  logic             wen_BHT;
  logic             wen_BTB;
  logic             halted;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, is_branch, is_halt, actual_taken, actual_target,
           IF_ID_prediction, IF_ID_predicted_target, hazard_stall,
    input  pc_en, IF_ID_en, IF_ID_flush, update_PC, wen_BHT, wen_BTB, halted,
           branch_cnt, mispredict_cnt, stall_cnt
  );

  modport slave (
    input  id_valid, is_branch, is_halt, actual_taken, actual_target,
           IF_ID_prediction, IF_ID_predicted_target, hazard_stall,
    output pc_en, IF_ID_en, IF_ID_flush, update_PC, wen_BHT, wen_BTB, halted,
           branch_cnt, mispredict_cnt, stall_cnt
  );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: compares decode-resolved branches with the
// pipelined BHT/BTB prediction and sequences a RUN/FLUSH/HALT FSM so every
// redirect costs a fixed penalty of FLUSH_CYCLES cycles.
// Optional build macro FETCH_PERF_CNT_EN adds saturating performance
// counters; without it the counter outputs are tied to zero.
module fetch_redirect_ctrl #(
  parameter int CNT_W        = 16,
  parameter int FLUSH_CYCLES = 1
) (
  input logic             clk,
  input logic             rst,
  fetch_redirect_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] flush_ctr_q, flush_ctr_d;

  logic mispred;
  logic tgt_miss;
  logic resolve;
  logic redirect;
  logic pc_en;
  logic if_id_en;
  logic if_id_flush;
  logic update_pc;
  logic wen_bht;
  logic wen_btb;
  logic halted;

  assign mispred  = bus.IF_ID_prediction[1] ^ bus.actual_taken;
  assign tgt_miss = bus.IF_ID_predicted_target != bus.actual_target;

  // Next-state and combinational control outputs; reset overrides everything last.
  always_comb begin
    state_d     = state_q;
    flush_ctr_d = flush_ctr_q;
    resolve     = 1'b0;
    redirect    = 1'b0;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    update_pc   = 1'b0;
    wen_bht     = 1'b0;
    wen_btb     = 1'b0;
    halted      = 1'b0;
    case (state_q)
      RUN: begin
        pc_en       = ~bus.hazard_stall;
        if_id_en    = ~bus.hazard_stall;
        resolve     = bus.id_valid & bus.is_branch & ~bus.hazard_stall;
        redirect    = resolve & (mispred | (bus.actual_taken & tgt_miss));
        wen_bht     = resolve & mispred;
        wen_btb     = resolve & bus.actual_taken & tgt_miss;
        update_pc   = redirect;
        if_id_flush = redirect;
        if (redirect) begin
          state_d     = FLUSH;
          flush_ctr_d = FLUSH_INIT;
        end else if (bus.id_valid & bus.is_halt & ~bus.is_branch & ~bus.hazard_stall) begin
          // A branch sharing the slot with a halt wins; the halt is dropped.
          state_d = HALT;
        end
      end
      FLUSH: begin
        // Bubbles only in flight here, so the stall request is irrelevant.
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = flush_ctr_q != 2'd0;
        if (flush_ctr_q == 2'd0) state_d = RUN;
        else                     flush_ctr_d = flush_ctr_q - 2'd1;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    if (rst) begin
      state_d     = RUN;
      flush_ctr_d = 2'd0;
      resolve     = 1'b0;
      redirect    = 1'b0;
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      update_pc   = 1'b0;
      wen_bht     = 1'b0;
      wen_btb     = 1'b0;
      halted      = 1'b0;
    end
  end

  // FSM state and flush countdown registers.
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    flush_ctr_q <= flush_ctr_d;
  end

  assign bus.pc_en       = pc_en;
  assign bus.IF_ID_en    = if_id_en;
  assign bus.IF_ID_flush = if_id_flush;
  assign bus.update_PC   = update_pc;
  assign bus.wen_BHT     = wen_bht;
  assign bus.wen_BTB     = wen_btb;
  assign bus.halted      = halted;

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  // Saturating event counters; stalls are not counted once halted.
  always_comb begin
    branch_cnt_d     = sat_inc(branch_cnt_q, resolve);
    mispredict_cnt_d = sat_inc(mispredict_cnt_q, redirect);
    stall_cnt_d      = sat_inc(stall_cnt_q, ~pc_en & (state_q != HALT));
    if (rst) begin
      branch_cnt_d     = '0;
      mispredict_cnt_d = '0;
      stall_cnt_d      = '0;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    branch_cnt_q     <= branch_cnt_d;
    mispredict_cnt_q <= mispredict_cnt_d;
    stall_cnt_q      <= stall_cnt_d;
  end

  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispredict_cnt = mispredict_cnt_q;
  assign bus.stall_cnt      = stall_cnt_q;
`else
  assign bus.branch_cnt     = {CNT_W{1'b0}};
  assign bus.mispredict_cnt = {CNT_W{1'b0}};
  assign bus.stall_cnt      = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: two instances (FLUSH_CYCLES 1 and 3) share
// clk/rst. Stimulus pushes hand-computed expectations into a queue; a
// negedge monitor pops and compares them against the selected instance.
module tb_fetch_redirect_ctrl;

  logic clk;
  logic rst;

  fetch_redirect_if #(.CNT_W(16)) bus_a ();
  fetch_redirect_if #(.CNT_W(16)) bus_b ();

  fetch_redirect_ctrl #(.CNT_W(16), .FLUSH_CYCLES(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  fetch_redirect_ctrl #(.CNT_W(16), .FLUSH_CYCLES(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output order: {pc_en, IF_ID_en, IF_ID_flush, update_PC, wen_BHT, wen_BTB, halted}
  typedef struct {
    string      nm;
    int         sel;
    logic [6:0] o;
    logic       chk;
    int         b;
    int         m;
    int         s;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic int cx(input int v);
`ifdef FETCH_PERF_CNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic ex(input string nm, input int sel, input logic [6:0] o,
                    input logic chk, input int b, input int m, input int s);
    exp_t e;
    e.nm = nm; e.sel = sel; e.o = o; e.chk = chk;
    e.b = cx(b); e.m = cx(m); e.s = cx(s);
    q.push_back(e);
  endtask

  task automatic drv(input int sel, input logic v, input logic br, input logic hl,
                     input logic tk, input logic [15:0] tgt, input logic [1:0] pr,
                     input logic [15:0] ptgt, input logic hs);
    if (sel == 0) begin
      bus_a.id_valid = v; bus_a.is_branch = br; bus_a.is_halt = hl;
      bus_a.actual_taken = tk; bus_a.actual_target = tgt;
      bus_a.IF_ID_prediction = pr; bus_a.IF_ID_predicted_target = ptgt;
      bus_a.hazard_stall = hs;
    end else begin
      bus_b.id_valid = v; bus_b.is_branch = br; bus_b.is_halt = hl;
      bus_b.actual_taken = tk; bus_b.actual_target = tgt;
      bus_b.IF_ID_prediction = pr; bus_b.IF_ID_predicted_target = ptgt;
      bus_b.hazard_stall = hs;
    end
  endtask

  task automatic idle(input int sel);
    drv(sel, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every expectation queued for this cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [6:0] got;
      int gb, gm, gs;
      e = q.pop_front();
      if (e.sel == 0) begin
        got = {bus_a.pc_en, bus_a.IF_ID_en, bus_a.IF_ID_flush, bus_a.update_PC,
               bus_a.wen_BHT, bus_a.wen_BTB, bus_a.halted};
        gb = int'(bus_a.branch_cnt); gm = int'(bus_a.mispredict_cnt); gs = int'(bus_a.stall_cnt);
      end else begin
        got = {bus_b.pc_en, bus_b.IF_ID_en, bus_b.IF_ID_flush, bus_b.update_PC,
               bus_b.wen_BHT, bus_b.wen_BTB, bus_b.halted};
        gb = int'(bus_b.branch_cnt); gm = int'(bus_b.mispredict_cnt); gs = int'(bus_b.stall_cnt);
      end
      n_chk++;
      if (got !== e.o) begin
        n_fail++;
        $display("FAIL %s outs: got %b expected %b", e.nm, got, e.o);
      end
      if (e.chk) begin
        n_chk++;
        if (gb != e.b || gm != e.m || gs != e.s) begin
          n_fail++;
          $display("FAIL %s counters: got b=%0d m=%0d s=%0d expected b=%0d m=%0d s=%0d",
                   e.nm, gb, gm, gs, e.b, e.m, e.s);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle(0);
    idle(1);
    ex("rst0_a", 0, 7'b0010000, 1'b0, 0, 0, 0);
    ex("rst0_b", 1, 7'b0010000, 1'b0, 0, 0, 0);
    tick();
    ex("rst1_a", 0, 7'b0010000, 1'b0, 0, 0, 0);
    ex("rst1_b", 1, 7'b0010000, 1'b0, 0, 0, 0);
    tick();
    rst = 1'b0;

    ex("idle_a", 0, 7'b1100000, 1'b1, 0, 0, 0);
    ex("idle_b", 1, 7'b1100000, 1'b1, 0, 0, 0);
    tick();
    drv(0, 1, 1, 0, 1, 16'h0040, 2'b10, 16'h0040, 0);
    ex("br_hit", 0, 7'b1100000, 1'b1, 0, 0, 0);
    tick();
    idle(0);
    ex("post_hit", 0, 7'b1100000, 1'b1, 1, 0, 0);
    tick();
    drv(0, 1, 1, 0, 1, 16'h0080, 2'b01, 16'h0040, 0);
    ex("redir", 0, 7'b1111110, 1'b1, 1, 0, 0);
    tick();
    ex("flush1", 0, 7'b1100000, 1'b1, 2, 1, 0);
    tick();
    idle(0);
    ex("run_back", 0, 7'b1100000, 1'b1, 2, 1, 0);
    tick();
    drv(0, 1, 1, 0, 0, 16'h0012, 2'b10, 16'h0040, 1);
    ex("stall1", 0, 7'b0000000, 1'b1, 2, 1, 0);
    tick();
    ex("stall2", 0, 7'b0000000, 1'b1, 2, 1, 1);
    tick();
    drv(0, 1, 1, 0, 0, 16'h0012, 2'b10, 16'h0040, 0);
    ex("stall_redir", 0, 7'b1111100, 1'b1, 2, 1, 2);
    tick();
    idle(0);
    ex("flush2", 0, 7'b1100000, 1'b1, 3, 2, 2);
    tick();
    drv(0, 1, 1, 1, 1, 16'h0040, 2'b10, 16'h0040, 0);
    ex("br_and_halt", 0, 7'b1100000, 1'b1, 3, 2, 2);
    tick();
    drv(0, 1, 0, 1, 0, 16'h0, 2'b00, 16'h0, 1);
    ex("halt_stalled", 0, 7'b0000000, 1'b1, 4, 2, 2);
    tick();
    drv(0, 0, 0, 1, 0, 16'h0, 2'b00, 16'h0, 0);
    ex("halt_novalid", 0, 7'b1100000, 1'b1, 4, 2, 3);
    tick();
    drv(0, 1, 0, 1, 0, 16'h0, 2'b00, 16'h0, 0);
    ex("halt_take", 0, 7'b1100000, 1'b1, 4, 2, 3);
    tick();
    drv(0, 1, 1, 0, 1, 16'h0080, 2'b01, 16'h0040, 0);
    ex("halted", 0, 7'b0000001, 1'b1, 4, 2, 3);
    tick();
    drv(0, 1, 1, 0, 1, 16'h0080, 2'b01, 16'h0040, 1);
    ex("halted_stall", 0, 7'b0000001, 1'b1, 4, 2, 3);
    tick();
    idle(0);

    drv(1, 1, 1, 0, 0, 16'h0012, 2'b11, 16'h0040, 0);
    ex("b_redir", 1, 7'b1111100, 1'b1, 0, 0, 0);
    tick();
    idle(1);
    ex("b_fl1", 1, 7'b1110000, 1'b1, 1, 1, 0);
    tick();
    drv(1, 0, 0, 0, 0, 16'h0, 2'b00, 16'h0, 1);
    ex("b_fl2", 1, 7'b1110000, 1'b1, 1, 1, 0);
    tick();
    idle(1);
    ex("b_fl3", 1, 7'b1100000, 1'b1, 1, 1, 0);
    tick();
    ex("b_run", 1, 7'b1100000, 1'b1, 1, 1, 0);
    tick();
    drv(1, 1, 1, 0, 1, 16'h0080, 2'b01, 16'h0080, 0);
    ex("b_redir2", 1, 7'b1111100, 1'b1, 1, 1, 0);
    tick();
    idle(1);
    ex("b_fl_mid", 1, 7'b1110000, 1'b1, 2, 2, 0);
    tick();
    rst = 1'b1;
    ex("rst_mid_a", 0, 7'b0010000, 1'b0, 0, 0, 0);
    ex("rst_mid_b", 1, 7'b0010000, 1'b0, 0, 0, 0);
    tick();
    rst = 1'b0;
    ex("post_rst_a", 0, 7'b1100000, 1'b1, 0, 0, 0);
    ex("post_rst_b", 1, 7'b1100000, 1'b1, 0, 0, 0);
    tick();
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
